// File: rtl/run_detect_sched.sv
// Round-robin shared consecutive-ones run detector: grants one serial lane per frame,
// reports runs of RUN_LEN ones. Optional macro RDS_EARLY_END_EN ends a frame on its first hit.
module run_detect_sched #(
  parameter int NCH       = 4,
  parameter int FRAME_LEN = 8,
  parameter int RUN_LEN   = 3,
  localparam int CHW      = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] bit_in,
  output logic [NCH-1:0] gnt,
  output logic           busy,
  output logic           hit_vld,
  output logic [CHW-1:0] hit_ch,
  output logic           done,
  output logic           frame_hit,
  output logic           abort
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CHW-1:0] ptr;
  logic [CHW-1:0] pick;
  logic [7:0]     bit_cnt;
  logic [3:0]     run_cnt;
  logic           hit_seen;
  logic           abort_r;
  logic           lane_req;
  logic           lane_bit;
  logic           hit_now;
  logic           last_bit;
  logic           end_now;

  // First requester strictly after the pointer, wrapping around.
  function automatic logic [CHW-1:0] rr_pick(input logic [NCH-1:0] r,
                                             input logic [CHW-1:0] p);
    logic [CHW-1:0] w;
    logic           f;
    int             j;
    w = p;
    f = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      j = (int'(p) + i) % NCH;
      if (!f && r[j[CHW-1:0]]) begin
        w = j[CHW-1:0];
        f = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [3:0] run_next(input logic [3:0] c, input logic b);
    if (!b) return 4'd0;
    if (c >= 4'(RUN_LEN)) return 4'(RUN_LEN);
    return c + 4'd1;
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] idx);
    logic [NCH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign pick     = rr_pick(req, ptr);
  assign lane_req = req[hit_ch];
  assign lane_bit = bit_in[hit_ch];
  assign hit_now  = lane_bit && (run_cnt == 4'(RUN_LEN - 1));
  assign last_bit = (bit_cnt == 8'(FRAME_LEN - 1));

`ifdef RDS_EARLY_END_EN
  assign end_now = last_bit || hit_now;
`else
  assign end_now = last_bit;
`endif

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign frame_hit = done && hit_seen;
  assign abort     = done && abort_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = RUN;
      RUN:     if (!lane_req || end_now) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt      <= '0;
      hit_ch   <= '0;
      ptr      <= CHW'(NCH - 1);
      bit_cnt  <= '0;
      run_cnt  <= '0;
      hit_vld  <= 1'b0;
      hit_seen <= 1'b0;
      abort_r  <= 1'b0;
    end else begin
      hit_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt      <= onehot(pick);
            hit_ch   <= pick;
            ptr      <= pick;
            bit_cnt  <= '0;
            run_cnt  <= '0;
            hit_seen <= 1'b0;
            abort_r  <= 1'b0;
          end
        end
        RUN: begin
          // A dropped request consumes the edge without sampling the lane.
          if (!lane_req) begin
            gnt     <= '0;
            abort_r <= 1'b1;
          end else begin
            run_cnt <= run_next(run_cnt, lane_bit);
            bit_cnt <= bit_cnt + 8'd1;
            hit_vld <= hit_now;
            if (hit_now) hit_seen <= 1'b1;
            if (end_now) gnt <= '0;
          end
        end
        DONE: begin
          bit_cnt  <= '0;
          run_cnt  <= '0;
          hit_seen <= 1'b0;
          abort_r  <= 1'b0;
        end
        default: gnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_run_detect_sched.sv
// Scoreboard bench for run_detect_sched: hit/done events are queued as stimulus is driven
// and popped by a negedge monitor; each test task also checks grant and hit timing inline.
module tb_run_detect_sched;
  localparam int NCH = 4;
  localparam int FL  = 8;
  localparam int RL  = 3;
`ifdef RDS_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] req;
  logic [NCH-1:0] bit_in;
  logic [NCH-1:0] gnt;
  logic           busy;
  logic           hit_vld;
  logic [1:0]     hit_ch;
  logic           done;
  logic           frame_hit;
  logic           abort;

  typedef struct packed {
    logic       kind;   // 0 = hit, 1 = done
    logic [1:0] ch;
    logic       fh;
    logic       ab;
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  run_detect_sched #(.NCH(NCH), .FRAME_LEN(FL), .RUN_LEN(RL)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt), .busy(busy),
    .hit_vld(hit_vld), .hit_ch(hit_ch), .done(done), .frame_hit(frame_hit), .abort(abort)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      if (hit_vld) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_hit: unexpected hit_vld ch=%0d, none expected", hit_ch);
        end else begin
          e = sb.pop_front();
          if (e.kind !== 1'b0 || hit_ch !== e.ch) begin
            n_fail++;
            $display("FAIL sb_hit: got hit ch=%0d, expected kind=%0d ch=%0d", hit_ch, e.kind, e.ch);
          end
        end
      end
      if (done) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_done: unexpected done ch=%0d fh=%0d ab=%0d", hit_ch, frame_hit, abort);
        end else begin
          e = sb.pop_front();
          if (e.kind !== 1'b1 || hit_ch !== e.ch || frame_hit !== e.fh || abort !== e.ab) begin
            n_fail++;
            $display("FAIL sb_done: got ch=%0d fh=%0d ab=%0d, expected kind=%0d ch=%0d fh=%0d ab=%0d",
                     hit_ch, frame_hit, abort, e.kind, e.ch, e.fh, e.ab);
          end
        end
      end else begin
        n_tests++;
        if (frame_hit !== 1'b0 || abort !== 1'b0) begin
          n_fail++;
          $display("FAIL quiet_flags: frame_hit=%0d abort=%0d outside done, expected 0 0", frame_hit, abort);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    n_tests++;
    if ({gnt, busy, hit_vld, hit_ch, done, frame_hit, abort} !== '0) begin
      n_fail++;
      $display("FAIL %s: gnt=%b busy=%0d hit_vld=%0d hit_ch=%0d done=%0d fh=%0d ab=%0d, expected all 0",
               name, gnt, busy, hit_vld, hit_ch, done, frame_hit, abort);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    req = '0; bit_in = '0; rst = 1'b0;
    #1 check_zero("reset_state");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
  endtask

  // Drives one frame on lane ch (bits[i] is the i-th sampled bit); drop_at < FL drops req there.
  task automatic run_frame(input logic [3:0] reqv, input int ch, input logic [7:0] bits,
                           input int drop_at);
    int         rc;
    logic       fh, hit, last;
    logic [3:0] oh;
    ev_t        e;
    oh = 4'b0001 << ch;
    rc = 0; fh = 1'b0;
    req = reqv;
    @(posedge clk); #1;
    n_tests++;
    if (gnt !== oh || busy !== 1'b1 || hit_ch !== 2'(ch)) begin
      n_fail++;
      $display("FAIL grant: gnt=%b busy=%0d hit_ch=%0d, expected gnt=%b busy=1 hit_ch=%0d",
               gnt, busy, hit_ch, oh, ch);
    end
    for (int i = 0; i < FL; i++) begin
      if (i == drop_at) begin
        req = reqv & ~oh;
        e.kind = 1'b1; e.ch = 2'(ch); e.fh = fh; e.ab = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        n_tests++;
        if (gnt !== 4'b0000 || done !== 1'b1 || hit_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_done: gnt=%b done=%0d hit_vld=%0d, expected 0000 1 0", gnt, done, hit_vld);
        end
        break;
      end
      bit_in = 4'($urandom);
      bit_in[ch] = bits[i];
      hit = bits[i] && (rc == RL - 1);
      rc  = bits[i] ? ((rc < RL) ? rc + 1 : RL) : 0;
      if (hit) begin
        fh = 1'b1;
        e.kind = 1'b0; e.ch = 2'(ch); e.fh = 1'b0; e.ab = 1'b0;
        sb.push_back(e);
      end
      last = (i == FL - 1) || (EARLY && hit);
      if (last) begin
        e.kind = 1'b1; e.ch = 2'(ch); e.fh = fh; e.ab = 1'b0;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      n_tests++;
      if (hit_vld !== hit) begin
        n_fail++;
        $display("FAIL hit_timing: bit %0d hit_vld=%0d, expected %0d", i, hit_vld, hit);
      end
      n_tests++;
      if (last) begin
        if (gnt !== 4'b0000 || done !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL frame_end: gnt=%b done=%0d busy=%0d, expected 0000 1 1", gnt, done, busy);
        end
        break;
      end else if (gnt !== oh || done !== 1'b0) begin
        n_fail++;
        $display("FAIL gnt_hold: bit %0d gnt=%b done=%0d, expected %b 0", i, gnt, done, oh);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_gap: busy=%0d gnt=%b done=%0d, expected 0 0000 0", busy, gnt, done);
    end
  endtask

  task automatic test_single_hit();
    test_reset();
    run_frame(4'b0001, 0, 8'b0000_0111, FL);
    req = '0;
  endtask

  task automatic test_round_robin();
    test_reset();
    run_frame(4'b1111, 0, 8'($urandom), FL);
    run_frame(4'b1111, 1, 8'($urandom), FL);
    run_frame(4'b1111, 2, 8'($urandom), FL);
    run_frame(4'b1111, 3, 8'($urandom), FL);
    run_frame(4'b1111, 0, 8'($urandom), FL);
    req = '0;
  endtask

  task automatic test_rearm();
    test_reset();
    run_frame(4'b0001, 0, 8'b1111_0111, FL);
    run_frame(4'b0001, 0, 8'b1101_1011, FL);
    run_frame(4'b0001, 0, 8'b1111_1111, FL);
    req = '0;
  endtask

  task automatic test_abort();
    test_reset();
    run_frame(4'b1100, 2, 8'b0000_1110, 4);
    run_frame(4'b1111, 3, 8'b0000_0000, FL);
    run_frame(4'b0110, 1, 8'b0000_0011, 0);
    req = '0;
  endtask

  task automatic test_reset_mid_frame();
    test_reset();
    run_frame(4'b1111, 0, 8'b0000_0000, FL);
    run_frame(4'b1111, 1, 8'b0000_0000, FL);
    req = 4'b1111;
    bit_in = '0;
    @(posedge clk); #1;
    n_tests++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_grant: gnt=%b, expected 0100", gnt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_zero("reset_async");
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_sb: %0d events pending, expected 0", sb.size());
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (gnt !== 4'b0001 || hit_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ptr: gnt=%b hit_ch=%0d, expected 0001 0", gnt, hit_ch);
    end
    test_reset();
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int k = 0; k < 6; k++)
      run_frame(4'b0101, (k % 2 == 0) ? 0 : 2, 8'($urandom), FL);
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d events still pending, expected 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b0; req = '0; bit_in = '0;
    test_single_hit();
    test_round_robin();
    test_rearm();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_detect_sched.md
Name: run_detect_sched

Overview:
Round-robin scheduler that shares one consecutive-ones run detector among NCH serial bit sources. Each granted requester gets a frame of FRAME_LEN bits. The block runs the detector over that frame, reports each run of RUN_LEN ones with the source channel, and clears the detector state between frames. It sits between the per-channel serial inputs and the downstream status/event logic.

Parameters:
NCH, 4, number of requesting channels (2..8)
FRAME_LEN, 8, bits sampled per grant (>= RUN_LEN, <= 255)
RUN_LEN, 3, consecutive ones that constitute a hit (1..15)
CHW (localparam), $clog2(NCH), width of channel index

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
req  in  NCH  per-channel request level; held high for the whole frame
bit_in  in  NCH  per-channel serial data; only the granted lane is sampled
gnt  out  NCH  one-hot grant, high for the whole frame
busy  out  1  high while a frame is in progress (RUN or DONE)
hit_vld  out  1  one-cycle pulse per detected run
hit_ch  out  CHW  channel index of the current grant; valid with hit_vld and done
done  out  1  one-cycle pulse at end of frame
frame_hit  out  1  valid with done; 1 if at least one hit in the frame
abort  out  1  valid with done; 1 if the frame ended because req dropped

Behaviour:
- Reset (rst=0, asynchronous) clears all outputs to 0, state to IDLE, and run/bit counters to 0. The RR pointer is set to NCH-1, so channel 0 has first priority.
- The FSM has three registered states: IDLE, RUN, DONE.
- IDLE:
  - gnt=0 and busy=0.
  - If req!=0, select the first set req bit scanning upward from pointer+1 with wrap-around.
  - Next cycle: gnt=onehot(winner), hit_ch=winner, state=RUN, bit_cnt=0, run_cnt=0, frame_hit=0. The RR pointer updates to the winner.
- RUN:
  - Every rising edge samples bit_in[winner].
  - run_cnt: a 1 increments it, saturating at RUN_LEN; a 0 clears it to 0.
  - bit_cnt increments on every sampling edge.
- Hit:
  - A hit is the sampling edge where run_cnt goes from RUN_LEN-1 to RUN_LEN.
  - hit_vld is registered and is high in the cycle after that edge.
  - Sampling continues while hit_vld is high. Further ones keep run_cnt saturated and produce no new hit.
  - A 0 re-arms the detector, so "1110111" yields two hits for RUN_LEN=3.
  - The sticky frame_hit is set by any hit.
- Frame end:
  - On the FRAME_LEN-th sampling edge, the next cycle is DONE.
  - In DONE: gnt=0, done=1, busy=1, abort=0, and frame_hit is final.
  - A hit completed by the final bit asserts hit_vld in the same DONE cycle.
- Abort:
  - If req[winner]=0 at any RUN edge, that edge samples nothing and the next state is DONE with abort=1.
  - frame_hit reflects only the bits sampled before the drop.
- DONE always lasts one cycle, then IDLE. Arbitration runs in the IDLE cycle, so back-to-back frames have a 2-cycle gap between gnt deassert and the next gnt assert.
- Requests from other channels during RUN are ignored; they are considered only at the next arbitration.
- Latency from a req rising edge in IDLE to gnt is 1 cycle. A full frame occupies FRAME_LEN RUN cycles plus 1 DONE cycle.
- hit_ch holds its value until the next grant.
- frame_hit and abort are zero except in the DONE cycle.

Optional Feature:
RDS_EARLY_END_EN
- Defined: the sampling edge that produces a hit also ends the frame. The next cycle is DONE, with hit_vld=1, done=1, frame_hit=1 and abort=0 in the same cycle. The remaining bits are not sampled.
- Undefined: frames always run FRAME_LEN bits unless aborted.

Test Plan:
1. NCH=4, FRAME_LEN=8, RUN_LEN=3; req=0001, lane0 bits 1,1,1,0,0,0,0,0 -> gnt=0001 for 8 cycles; one hit_vld with hit_ch=0 the cycle after the 3rd bit; done=1, frame_hit=1, abort=0.
2. req=1111 held for 5 frames -> gnt sequence 0001, 0010, 0100, 1000, 0001; 2-cycle gap between frames; busy=0 only in the IDLE cycles.
3. Lane bits 1,1,1,0,1,1,1,1 -> two hit_vld pulses, after bit 3 and after bit 7. Bits 1,1,0,1,1,0,1,1 -> no hit, done with frame_hit=0.
4. req[2] dropped before the 5th sample, with bits 0,1,1,1 already sampled -> DONE next cycle with abort=1, frame_hit=1, hit_ch=2; the next grant goes to the next requester above 2.
5. rst pulsed low mid-frame with req=1111 and pointer at 2 -> all outputs 0 immediately; after release, the first gnt=0001.
6. With RDS_EARLY_END_EN, bits 1,1,1,x... -> hit_vld, done and frame_hit all high in the cycle after the 3rd bit; gnt lasts 3 cycles. Without the macro, gnt lasts 8 cycles.
